// File: rtl/x2050_gstat_pkg.sv
// Shared constants for the G-register status / length-loop block:
// FSM state encodings, branch-test select codes and exhaustion chain codes.
package x2050_gstat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2,
        ST_DONE = 2'd3
    } gstate_e;

    // Branch test select codes (control word gtest field)
    localparam logic [2:0] GT_NONE  = 3'd0;
    localparam logic [2:0] GT_G1Z   = 3'd1;
    localparam logic [2:0] GT_G2Z   = 3'd2;
    localparam logic [2:0] GT_BOTHZ = 3'd3;
    localparam logic [2:0] GT_G1S   = 3'd4;
    localparam logic [2:0] GT_G2S   = 3'd5;
    localparam logic [2:0] GT_ANYS  = 3'd6;
    localparam logic [2:0] GT_LAST  = 3'd7;

    // Exhaustion source select
    localparam logic [1:0] CH_NONE = 2'd0;
    localparam logic [1:0] CH_G1   = 2'd1;
    localparam logic [1:0] CH_G2   = 2'd2;
    localparam logic [1:0] CH_ANY  = 2'd3;

    localparam logic [7:0] ITER_MAX = 8'hFF;

    // True when the latched sign(s) picked by the chain code show a borrow.
    function automatic logic chain_exhausted(input logic [1:0] chain,
                                             input logic       g1s,
                                             input logic       g2s);
        logic ex;
        case (chain)
            CH_G1:   ex = g1s;
            CH_G2:   ex = g2s;
            CH_ANY:  ex = g1s | g2s;
            default: ex = 1'b0;
        endcase
        return ex;
    endfunction

endpackage

// File: rtl/x2050_gstat_if.sv
// Control/status bundle between the ROS sequencer (master) and the
// G-status block (slave).
interface x2050_gstat_if;
    logic       i_ros_advance;
    logic       i_io_mode;
    logic [7:0] i_g_reg;
    logic       i_g1_sign;
    logic       i_g2_sign;
    logic [2:0] i_gtest;
    logic       i_start;
    logic       i_abort;
    logic [1:0] i_chain;
    logic       o_branch;
    logic       o_g1_zero;
    logic       o_g2_zero;
    logic [1:0] o_state;
    logic       o_busy;
    logic       o_last;
    logic       o_done;
    logic [7:0] o_iter;

    modport master (
        output i_ros_advance, i_io_mode, i_g_reg, i_g1_sign, i_g2_sign,
               i_gtest, i_start, i_abort, i_chain,
        input  o_branch, o_g1_zero, o_g2_zero, o_state, o_busy, o_last,
               o_done, o_iter
    );

    modport slave (
        input  i_ros_advance, i_io_mode, i_g_reg, i_g1_sign, i_g2_sign,
               i_gtest, i_start, i_abort, i_chain,
        output o_branch, o_g1_zero, o_g2_zero, o_state, o_busy, o_last,
               o_done, o_iter
    );
endinterface

// File: rtl/x2050_gstat_gtest.sv
// G status latch (nibble-zero and sign flags) plus the branch test mux.
// Latches are frozen during I/O mode cycles and between advances.
module x2050_gstat_gtest
    import x2050_gstat_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       advance_i,
    input  logic       io_mode_i,
    input  logic [7:0] g_reg_i,
    input  logic       g1_sign_i,
    input  logic       g2_sign_i,
    input  logic [2:0] gtest_i,
    input  logic       is_last_i,
    output logic       branch_o,
    output logic       g1_zero_o,
    output logic       g2_zero_o,
    output logic       g1_sign_o,
    output logic       g2_sign_o
);

    logic g1z_q, g2z_q, g1s_q, g2s_q;
    logic sample;

    assign sample = advance_i & ~io_mode_i;

    // Capture G status on qualified advances only
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            g1z_q <= 1'b0;
            g2z_q <= 1'b0;
            g1s_q <= 1'b0;
            g2s_q <= 1'b0;
        end else if (sample) begin
            g1z_q <= (g_reg_i[7:4] == 4'h0);
            g2z_q <= (g_reg_i[3:0] == 4'h0);
            g1s_q <= g1_sign_i;
            g2s_q <= g2_sign_i;
        end
    end

    // Branch test select
    always_comb begin
        branch_o = 1'b0;
        case (gtest_i)
            GT_G1Z:   branch_o = g1z_q;
            GT_G2Z:   branch_o = g2z_q;
            GT_BOTHZ: branch_o = g1z_q & g2z_q;
            GT_G1S:   branch_o = g1s_q;
            GT_G2S:   branch_o = g2s_q;
            GT_ANYS:  branch_o = g1s_q | g2s_q;
            GT_LAST:  branch_o = is_last_i;
            default:  branch_o = 1'b0;
        endcase
    end

    assign g1_zero_o = g1z_q;
    assign g2_zero_o = g2z_q;
    assign g1_sign_o = g1s_q;
    assign g2_sign_o = g2s_q;

endmodule

// File: rtl/x2050_gstat.sv
// G-register status and length-controlled loop sequencer. The loop runs
// until the latched sign(s) chosen by i_chain show a borrow, then walks
// LAST -> DONE -> IDLE one advance at a time. o_iter counts RUN advances.
module x2050_gstat
    import x2050_gstat_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset_n,
    x2050_gstat_if.slave  bus
);

    gstate_e    state_q, state_d;
    logic [7:0] iter_q, iter_d;
    logic       g1s, g2s;
    logic       is_last;

    assign is_last = (state_q == ST_LAST);

    x2050_gstat_gtest u_gtest (
        .clk_i     (i_clk),
        .rst_n_i   (i_reset_n),
        .advance_i (bus.i_ros_advance),
        .io_mode_i (bus.i_io_mode),
        .g_reg_i   (bus.i_g_reg),
        .g1_sign_i (bus.i_g1_sign),
        .g2_sign_i (bus.i_g2_sign),
        .gtest_i   (bus.i_gtest),
        .is_last_i (is_last),
        .branch_o  (bus.o_branch),
        .g1_zero_o (bus.o_g1_zero),
        .g2_zero_o (bus.o_g2_zero),
        .g1_sign_o (g1s),
        .g2_sign_o (g2s)
    );

    // State and iteration counter registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            iter_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state and counter update; abort outranks everything.
    // Exhaustion looks at the latch value from before this edge.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        if (bus.i_ros_advance) begin
            if (bus.i_abort) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.i_start) begin
                            state_d = ST_RUN;
                            iter_d  = 8'h00;
                        end
                    end
                    ST_RUN: begin
                        if (iter_q != ITER_MAX)
                            iter_d = iter_q + 8'd1;
                        if (chain_exhausted(bus.i_chain, g1s, g2s))
                            state_d = ST_LAST;
                    end
                    ST_LAST: state_d = ST_DONE;
                    ST_DONE: state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_state = state_q;
    assign bus.o_busy  = (state_q == ST_RUN) || (state_q == ST_LAST);
    assign bus.o_last  = is_last;
    assign bus.o_done  = (state_q == ST_DONE);
    assign bus.o_iter  = iter_q;

endmodule

// File: tb/tb_x2050_gstat.sv
// Directed bench for x2050_gstat: expectations are queued as stimulus is
// applied and drained against the DUT after the corresponding clock.
module tb_x2050_gstat;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    x2050_gstat_if bus();

    x2050_gstat dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] K_STATE = 4'd0, K_ITER = 4'd1, K_BR = 4'd2,
                           K_G1Z = 4'd3, K_G2Z = 4'd4, K_BUSY = 4'd5,
                           K_LAST = 4'd6, K_DONE = 4'd7;

    typedef struct packed {
        logic [3:0] k;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];

    function automatic logic [7:0] obs(input logic [3:0] k);
        case (k)
            K_STATE: return {6'd0, bus.o_state};
            K_ITER:  return bus.o_iter;
            K_BR:    return {7'd0, bus.o_branch};
            K_G1Z:   return {7'd0, bus.o_g1_zero};
            K_G2Z:   return {7'd0, bus.o_g2_zero};
            K_BUSY:  return {7'd0, bus.o_busy};
            K_LAST:  return {7'd0, bus.o_last};
            default: return {7'd0, bus.o_done};
        endcase
    endfunction

    function automatic string kname(input logic [3:0] k);
        case (k)
            K_STATE: return "state";
            K_ITER:  return "iter";
            K_BR:    return "branch";
            K_G1Z:   return "g1_zero";
            K_G2Z:   return "g2_zero";
            K_BUSY:  return "busy";
            K_LAST:  return "last";
            default: return "done";
        endcase
    endfunction

    task automatic expect_v(input logic [3:0] k, input logic [7:0] v);
        exp_t e;
        e.k = k;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [7:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = obs(e.k);
            checks++;
            assert (got === e.v) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", kname(e.k), got, e.v);
            end
        end
    endtask

    // One clock; inputs and samples both settle 1ns after the rising edge
    task automatic tick(input logic adv);
        bus.i_ros_advance = adv;
        @(posedge clk);
        #1;
        bus.i_ros_advance = 1'b0;
    endtask

    task automatic set_gtest(input logic [2:0] g);
        bus.i_gtest = g;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.i_ros_advance = 1'b0;
        bus.i_io_mode = 1'b0;
        bus.i_g_reg = 8'h00;
        bus.i_g1_sign = 1'b0;
        bus.i_g2_sign = 1'b0;
        bus.i_gtest = 3'd7;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_chain = 2'd0;
        #3;
        expect_v(K_STATE, 8'd0); expect_v(K_ITER, 8'd0); expect_v(K_BR, 8'd0);
        expect_v(K_G1Z, 8'd0); expect_v(K_BUSY, 8'd0);
        drain();
        tick(1'b0);
        rst_n = 1'b1;
        tick(1'b0);

        // Nibble-zero tests
        bus.i_g_reg = 8'h05;
        tick(1'b1);
        expect_v(K_G1Z, 8'd1); expect_v(K_G2Z, 8'd0); drain();
        set_gtest(3'd1); expect_v(K_BR, 8'd1); drain();
        set_gtest(3'd2); expect_v(K_BR, 8'd0); drain();
        set_gtest(3'd3); expect_v(K_BR, 8'd0); drain();
        set_gtest(3'd7); expect_v(K_BR, 8'd0); drain();

        // Sign tests
        bus.i_g1_sign = 1'b1;
        tick(1'b1);
        set_gtest(3'd4); expect_v(K_BR, 8'd1); drain();
        set_gtest(3'd5); expect_v(K_BR, 8'd0); drain();
        set_gtest(3'd6); expect_v(K_BR, 8'd1); drain();

        // Without advance nothing moves
        bus.i_g_reg = 8'h00; bus.i_g2_sign = 1'b1; bus.i_start = 1'b1;
        tick(1'b0);
        set_gtest(3'd5); expect_v(K_BR, 8'd0); expect_v(K_G2Z, 8'd0);
        expect_v(K_STATE, 8'd0); drain();
        bus.i_start = 1'b0; bus.i_g1_sign = 1'b0; bus.i_g2_sign = 1'b0;
        tick(1'b1);

        // Full loop on G2 exhaustion
        bus.i_chain = 2'd2; bus.i_start = 1'b1;
        tick(1'b1);
        bus.i_start = 1'b0;
        expect_v(K_STATE, 8'd1); expect_v(K_ITER, 8'd0); expect_v(K_BUSY, 8'd1); drain();
        for (int i = 1; i <= 3; i++) begin
            tick(1'b1);
            expect_v(K_STATE, 8'd1); expect_v(K_ITER, 8'(i)); drain();
        end
        bus.i_g2_sign = 1'b1;
        tick(1'b1);
        expect_v(K_STATE, 8'd1); expect_v(K_ITER, 8'd4); drain();
        tick(1'b1);
        set_gtest(3'd7);
        expect_v(K_STATE, 8'd2); expect_v(K_ITER, 8'd5); expect_v(K_LAST, 8'd1);
        expect_v(K_BUSY, 8'd1); expect_v(K_BR, 8'd1); drain();
        tick(1'b0);
        expect_v(K_STATE, 8'd2); drain();
        tick(1'b1);
        expect_v(K_STATE, 8'd3); expect_v(K_DONE, 8'd1); expect_v(K_BUSY, 8'd0);
        expect_v(K_ITER, 8'd5); expect_v(K_BR, 8'd0); drain();
        tick(1'b1);
        expect_v(K_STATE, 8'd0); expect_v(K_DONE, 8'd0); drain();
        bus.i_g2_sign = 1'b0;
        tick(1'b1);

        // Abort beats start in IDLE
        bus.i_start = 1'b1; bus.i_abort = 1'b1;
        tick(1'b1);
        expect_v(K_STATE, 8'd0); drain();
        bus.i_abort = 1'b0;
        bus.i_g2_sign = 1'b1;
        tick(1'b1);
        bus.i_start = 1'b0;
        expect_v(K_STATE, 8'd1); drain();
        tick(1'b1);
        expect_v(K_STATE, 8'd2); expect_v(K_ITER, 8'd1); drain();
        bus.i_abort = 1'b1;
        tick(1'b1);
        bus.i_abort = 1'b0;
        expect_v(K_STATE, 8'd0); expect_v(K_DONE, 8'd0); drain();
        bus.i_g2_sign = 1'b0;
        bus.i_g_reg = 8'h55;
        tick(1'b1);
        expect_v(K_G1Z, 8'd0); drain();

        // I/O mode freezes latches but not the counter
        bus.i_chain = 2'd0; bus.i_start = 1'b1;
        tick(1'b1);
        bus.i_start = 1'b0;
        bus.i_io_mode = 1'b1; bus.i_g_reg = 8'h00;
        tick(1'b1);
        expect_v(K_G1Z, 8'd0); expect_v(K_ITER, 8'd1); expect_v(K_STATE, 8'd1); drain();
        bus.i_io_mode = 1'b0;

        // Saturation
        for (int i = 0; i < 300; i++) tick(1'b1);
        expect_v(K_ITER, 8'd255); expect_v(K_STATE, 8'd1); expect_v(K_G1Z, 8'd1); drain();

        // Asynchronous reset mid-RUN
        set_gtest(3'd1);
        expect_v(K_BR, 8'd1); drain();
        #2;
        rst_n = 1'b0;
        #1;
        expect_v(K_STATE, 8'd0); expect_v(K_ITER, 8'd0); expect_v(K_BR, 8'd0);
        expect_v(K_DONE, 8'd0); drain();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1);
        expect_v(K_STATE, 8'd0); drain();
        bus.i_start = 1'b1;
        tick(1'b1);
        bus.i_start = 1'b0;
        expect_v(K_STATE, 8'd1); expect_v(K_ITER, 8'd0); drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/x2050_gstat.md
X2050_GSTAT -- requirements
Module: x2050gstat

Interface
REQ-001 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port i_reset_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port i_ros_advance  input  1  ROS cycle advance qualifier.
REQ-004 SHALL have port i_io_mode  input  1  I/O mode cycle; freezes sign/status latches.
REQ-005 SHALL have port i_g_reg  input  8  G length counter value (G1=[7:4], G2=[3:0]).
REQ-006 SHALL have port i_g1_sign  input  1  G1 borrow-out sign from the length counter.
REQ-007 SHALL have port i_g2_sign  input  1  G2 borrow-out sign from the length counter.
REQ-008 SHALL have port i_gtest  input  3  branch test select from the control word.
REQ-009 SHALL have port i_start  input  1  begin length-controlled loop (sampled on advance).
REQ-010 SHALL have port i_abort  input  1  abandon loop (sampled on advance).
REQ-011 SHALL have port i_chain  input  2  exhaustion source: 1=G1, 2=G2, 3=G1 or G2, 0=none.
REQ-012 SHALL have port o_branch  output  1  selected test result.
REQ-013 SHALL have port o_g1_zero, o_g2_zero  output  1 each  latched nibble-zero status.
REQ-014 SHALL have port o_state  output  2  FSM state encoding.
REQ-015 SHALL have port o_busy, o_last, o_done  output  1 each  loop status.
REQ-016 SHALL have port o_iter  output  8  advances spent in RUN.

Function
REQ-017 Status latch SHALL sample g1_zero=(i_g_reg[7:4]==0), g2_zero=(i_g_reg[3:0]==0), g1_sign, g2_sign on each clock with i_ros_advance=1 and i_io_mode=0; otherwise hold.
REQ-018 o_branch SHALL be combinational from latched status and state: gtest 0->0, 1->G1 zero, 2->G2 zero, 3->both zero, 4->G1 sign, 5->G2 sign, 6->G1 sign|G2 sign, 7->(state==LAST).
REQ-019 FSM states SHALL be IDLE=0, RUN=1, LAST=2, DONE=3; transitions only on clocks with i_ros_advance=1.
REQ-020 IDLE->RUN on i_start; i_start in any other state SHALL be ignored.
REQ-021 RUN->LAST when the latched sign(s) selected by i_chain are 1 (chain 0 never exhausts); evaluation uses the latch value before that edge's update.
REQ-022 LAST->DONE and DONE->IDLE SHALL each take exactly one advance.
REQ-023 i_abort SHALL force IDLE from any state and take priority over i_start and exhaustion.
REQ-024 o_busy=(RUN|LAST), o_last=(LAST), o_done=(DONE), each one advance long.
REQ-025 o_iter SHALL clear on IDLE->RUN, increment by 1 per advance in RUN, saturate at 255.
REQ-026 i_io_mode=1 SHALL freeze status latches but not the FSM or o_iter.
REQ-027 No output SHALL change on clocks with i_ros_advance=0.

Reset
REQ-028 i_reset_n=0 SHALL immediately clear all latches, o_iter=0, state=IDLE, o_branch=0, regardless of clock.
REQ-029 Reset assertion mid-loop SHALL abandon the loop with no o_done pulse; first post-reset advance behaves as from IDLE.

Structure
REQ-030 State encodings and gtest codes SHALL be constants in the shared x2050 package.
REQ-031 The status latch plus test mux SHALL be one sub-module, x2050gtest; FSM and counter live in the top.

Verification
REQ-032 Reset: assert i_reset_n=0 mid-RUN without clock -> state=0, o_iter=0, o_branch=0 at once.
REQ-033 Zero tests: i_g_reg=8'h05, advance, gtest=1 -> o_branch=1; gtest=2 -> 0; gtest=3 -> 0.
REQ-034 Loop: start, chain=2, g2_sign rises after 4 advances in RUN -> LAST next advance, DONE after, o_done one advance, o_iter=5.
REQ-035 Abort with start same advance in IDLE -> stays IDLE; abort in LAST -> IDLE, no o_done.
REQ-036 io_mode=1 with i_g_reg=0 on advance -> o_g1_zero unchanged; o_iter still increments in RUN.
REQ-037 Saturation: chain=0, 300 advances in RUN -> o_iter=255, state stays RUN.
